// File: rtl/writeback_arb_l6.sv
// Writeback arbiter: round-robin selection among execute-unit X->W channels into a
// one-entry completion register that feeds commit and the physical register file.
module writeback_arb_l6 #(
    parameter int p_num_pipes      = 3,
    parameter int p_seq_num_bits   = 5,
    parameter int p_phys_addr_bits = 6
) (
    input  logic                                    clk,
    input  logic                                    rst,

    input  logic [p_num_pipes-1:0]                  X_val,
    output logic [p_num_pipes-1:0]                  X_rdy,
    input  logic [p_num_pipes*32-1:0]               X_pc,
    input  logic [p_num_pipes*p_seq_num_bits-1:0]   X_seq_num,
    input  logic [p_num_pipes*5-1:0]                X_waddr,
    input  logic [p_num_pipes*32-1:0]               X_wdata,
    input  logic [p_num_pipes-1:0]                  X_wen,
    input  logic [p_num_pipes*p_phys_addr_bits-1:0] X_preg,
    input  logic [p_num_pipes*p_phys_addr_bits-1:0] X_ppreg,

    output logic                                    rf_wen,
    output logic [p_phys_addr_bits-1:0]             rf_waddr,
    output logic [31:0]                             rf_wdata,

    output logic                                    C_val,
    input  logic                                    C_rdy,
    output logic [31:0]                             C_pc,
    output logic [p_seq_num_bits-1:0]               C_seq_num,
    output logic [4:0]                              C_waddr,
    output logic [31:0]                             C_wdata,
    output logic                                    C_wen,
    output logic [p_phys_addr_bits-1:0]             C_preg,
    output logic [p_phys_addr_bits-1:0]             C_ppreg
);

    localparam int PTR_W = (p_num_pipes > 1) ? $clog2(p_num_pipes) : 1;
    localparam logic [PTR_W:0] NUM_S = (PTR_W+1)'(p_num_pipes);
    localparam logic [PTR_W:0] ONE_S = (PTR_W+1)'(1);

    // Writes to architectural x0 are dropped here so commit and the regfile never see them.
    function automatic logic eff_wen(input logic wen, input logic [4:0] waddr);
        return wen & (waddr != 5'd0);
    endfunction

    logic [PTR_W-1:0]            ptr_p1;
    logic [PTR_W-1:0]            nxt_ptr;
    logic [p_num_pipes-1:0]      grant;
    logic                        found;
    logic [PTR_W:0]              scan_idx;
    logic [PTR_W:0]              wrap_idx;
    logic                        can_accept;
    logic                        x_xfer;

    logic [31:0]                 sel_pc;
    logic [p_seq_num_bits-1:0]   sel_seq;
    logic [4:0]                  sel_waddr;
    logic [31:0]                 sel_wdata;
    logic                        sel_wen;
    logic [p_phys_addr_bits-1:0] sel_preg;
    logic [p_phys_addr_bits-1:0] sel_ppreg;

    logic                        vld_p1;
    logic [31:0]                 pc_p1;
    logic [p_seq_num_bits-1:0]   seq_p1;
    logic [4:0]                  waddr_p1;
    logic [31:0]                 wdata_p1;
    logic                        wen_p1;
    logic [p_phys_addr_bits-1:0] preg_p1;
    logic [p_phys_addr_bits-1:0] ppreg_p1;

    // Stage p0: round-robin scan starting at ptr, first valid pipe wins.
    always_comb begin
        grant    = '0;
        nxt_ptr  = ptr_p1;
        found    = 1'b0;
        scan_idx = '0;
        wrap_idx = '0;
        for (int k = 0; k < p_num_pipes; k++) begin
            scan_idx = {1'b0, ptr_p1} + (PTR_W+1)'(k);
            if (scan_idx >= NUM_S) begin
                scan_idx = scan_idx - NUM_S;
            end
            if (!found && X_val[scan_idx[PTR_W-1:0]]) begin
                found = 1'b1;
                grant[scan_idx[PTR_W-1:0]] = 1'b1;
                wrap_idx = scan_idx + ONE_S;
                if (wrap_idx >= NUM_S) begin
                    wrap_idx = '0;
                end
                nxt_ptr = wrap_idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        sel_pc    = '0;
        sel_seq   = '0;
        sel_waddr = '0;
        sel_wdata = '0;
        sel_wen   = 1'b0;
        sel_preg  = '0;
        sel_ppreg = '0;
        for (int i = 0; i < p_num_pipes; i++) begin
            if (grant[i]) begin
                sel_pc    = X_pc[32*i +: 32];
                sel_seq   = X_seq_num[p_seq_num_bits*i +: p_seq_num_bits];
                sel_waddr = X_waddr[5*i +: 5];
                sel_wdata = X_wdata[32*i +: 32];
                sel_wen   = X_wen[i];
                sel_preg  = X_preg[p_phys_addr_bits*i +: p_phys_addr_bits];
                sel_ppreg = X_ppreg[p_phys_addr_bits*i +: p_phys_addr_bits];
            end
        end
    end

    assign can_accept = ~vld_p1 | C_rdy;
    assign X_rdy      = grant & {p_num_pipes{can_accept}};
    assign x_xfer     = can_accept & found;

    // Stage p1: completion register; a new load takes priority over a plain drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_p1   <= '0;
            vld_p1   <= 1'b0;
            pc_p1    <= '0;
            seq_p1   <= '0;
            waddr_p1 <= '0;
            wdata_p1 <= '0;
            wen_p1   <= 1'b0;
            preg_p1  <= '0;
            ppreg_p1 <= '0;
        end else if (x_xfer) begin
            ptr_p1   <= nxt_ptr;
            vld_p1   <= 1'b1;
            pc_p1    <= sel_pc;
            seq_p1   <= sel_seq;
            waddr_p1 <= sel_waddr;
            wdata_p1 <= sel_wdata;
            wen_p1   <= eff_wen(sel_wen, sel_waddr);
            preg_p1  <= sel_preg;
            ppreg_p1 <= sel_ppreg;
        end else if (vld_p1 && C_rdy) begin
            vld_p1   <= 1'b0;
            pc_p1    <= '0;
            seq_p1   <= '0;
            waddr_p1 <= '0;
            wdata_p1 <= '0;
            wen_p1   <= 1'b0;
            preg_p1  <= '0;
            ppreg_p1 <= '0;
        end
    end

    assign C_val     = vld_p1;
    assign C_pc      = pc_p1;
    assign C_seq_num = seq_p1;
    assign C_waddr   = waddr_p1;
    assign C_wdata   = wdata_p1;
    assign C_wen     = wen_p1;
    assign C_preg    = preg_p1;
    assign C_ppreg   = ppreg_p1;

    // The regfile write fires only on the commit handshake, so each entry writes once.
    assign rf_wen   = vld_p1 & C_rdy & wen_p1;
    assign rf_waddr = preg_p1;
    assign rf_wdata = wdata_p1;

endmodule

// File: tb/tb_writeback_arb_l6.sv
// Randomized and directed bench for writeback_arb_l6 against a transaction-level model.
module tb_writeback_arb_l6;

    localparam int N  = 3;
    localparam int SB = 5;
    localparam int PB = 6;

    typedef struct packed {
        logic [31:0]   pc;
        logic [SB-1:0] seq;
        logic [4:0]    waddr;
        logic [31:0]   wdata;
        logic          wen;
        logic [PB-1:0] preg;
        logic [PB-1:0] ppreg;
    } txn_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]    X_val, X_rdy, X_wen;
    logic [N*32-1:0] X_pc, X_wdata;
    logic [N*SB-1:0] X_seq_num;
    logic [N*5-1:0]  X_waddr;
    logic [N*PB-1:0] X_preg, X_ppreg;
    logic            rf_wen;
    logic [PB-1:0]   rf_waddr;
    logic [31:0]     rf_wdata;
    logic            C_val, C_rdy, C_wen;
    logic [31:0]     C_pc, C_wdata;
    logic [SB-1:0]   C_seq_num;
    logic [4:0]      C_waddr;
    logic [PB-1:0]   C_preg, C_ppreg;

    writeback_arb_l6 #(.p_num_pipes(N), .p_seq_num_bits(SB), .p_phys_addr_bits(PB)) dut (
        .clk(clk), .rst(rst),
        .X_val(X_val), .X_rdy(X_rdy), .X_pc(X_pc), .X_seq_num(X_seq_num),
        .X_waddr(X_waddr), .X_wdata(X_wdata), .X_wen(X_wen),
        .X_preg(X_preg), .X_ppreg(X_ppreg),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .C_val(C_val), .C_rdy(C_rdy), .C_pc(C_pc), .C_seq_num(C_seq_num),
        .C_waddr(C_waddr), .C_wdata(C_wdata), .C_wen(C_wen),
        .C_preg(C_preg), .C_ppreg(C_ppreg)
    );

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;

    txn_t       pend [N];
    logic [N-1:0] pend_val;

    // Reference model state: one held completion and the round-robin start pipe.
    logic m_val;
    txn_t m_ent;
    int   m_ptr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic txn_t rand_txn();
        txn_t t;
        t.pc    = $urandom;
        t.seq   = SB'($urandom);
        t.waddr = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        t.wdata = $urandom;
        t.wen   = 1'($urandom);
        t.preg  = PB'($urandom);
        t.ppreg = PB'($urandom);
        return t;
    endfunction

    // One cycle: drive at negedge, check against the model, then advance the model.
    task automatic step(input logic c_rdy, input logic r, output int acc);
        int g;
        logic can;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        C_rdy = c_rdy;
        rst   = r;
        X_val = pend_val;
        for (int i = 0; i < N; i++) begin
            X_pc[i*32 +: 32]    = pend[i].pc;
            X_seq_num[i*SB +: SB] = pend[i].seq;
            X_waddr[i*5 +: 5]   = pend[i].waddr;
            X_wdata[i*32 +: 32] = pend[i].wdata;
            X_wen[i]            = pend[i].wen;
            X_preg[i*PB +: PB]  = pend[i].preg;
            X_ppreg[i*PB +: PB] = pend[i].ppreg;
        end
        #1;
        g = -1;
        for (int k = 0; k < N; k++) begin
            if (g < 0 && pend_val[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
        can = !m_val || c_rdy;
        exp_rdy = '0;
        if (can && g >= 0) exp_rdy[g] = 1'b1;
        check("x_rdy", X_rdy, exp_rdy);
        check("c_val", C_val, m_val);
        check("c_pc", C_pc, m_ent.pc);
        check("c_seq", C_seq_num, m_ent.seq);
        check("c_waddr", C_waddr, m_ent.waddr);
        check("c_wdata", C_wdata, m_ent.wdata);
        check("c_wen", C_wen, m_ent.wen);
        check("c_preg", C_preg, m_ent.preg);
        check("c_ppreg", C_ppreg, m_ent.ppreg);
        check("rf_wen", rf_wen, m_val && c_rdy && m_ent.wen);
        check("rf_waddr", rf_waddr, m_ent.preg);
        check("rf_wdata", rf_wdata, m_ent.wdata);
        acc = -1;
        if (r) begin
            m_val = 1'b0; m_ent = '0; m_ptr = 0;
        end else if (can && g >= 0) begin
            acc = g;
            m_val = 1'b1;
            m_ent = pend[g];
            m_ent.wen = pend[g].wen && (pend[g].waddr != 5'd0);
            m_ptr = (g + 1) % N;
        end else if (m_val && c_rdy) begin
            m_val = 1'b0; m_ent = '0;
        end
    endtask

    initial begin
        int acc;
        int cnt;
        int waits [N];
        logic c_rdy, r;

        rst = 1'b1; C_rdy = 1'b0; X_val = '0;
        X_pc = '0; X_seq_num = '0; X_waddr = '0; X_wdata = '0; X_wen = '0; X_preg = '0; X_ppreg = '0;
        pend_val = '0;
        for (int i = 0; i < N; i++) pend[i] = '0;
        m_val = 1'b0; m_ent = '0; m_ptr = 0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rst_cval", C_val, 0);
        check("rst_rfwen", rf_wen, 0);
        check("rst_seq", C_seq_num, 0);

        // Single pipe
        pend[1] = '{pc: 32'h100, seq: 5'd3, waddr: 5'd5, wdata: 32'h1234, wen: 1'b1, preg: 6'd9, ppreg: 6'd2};
        pend_val = 3'b010;
        step(1'b1, 1'b0, acc);
        check("sp_rdy", X_rdy, 3'b010);
        pend_val = '0;
        step(1'b1, 1'b0, acc);
        check("sp_seq", C_seq_num, 3);
        check("sp_rfwen", rf_wen, 1);
        check("sp_rfaddr", rf_waddr, 9);
        check("sp_rfdata", rf_wdata, 32'h1234);
        step(1'b1, 1'b0, acc);
        check("sp_cval_off", C_val, 0);

        // Contention from a freshly reset pointer
        step(1'b1, 1'b1, acc);
        for (int i = 0; i < N; i++) pend[i] = rand_txn();
        pend_val = 3'b111;
        for (int j = 0; j < 6; j++) begin
            step(1'b1, 1'b0, acc);
            check("cont_order", acc, j % N);
            if (j > 0) check("cont_cval", C_val, 1);
            if (acc >= 0) pend[acc] = rand_txn();
        end

        // Backpressure with pipe0 seq 7 held and pipe2 waiting
        pend[0].seq = 5'd7;
        pend_val = 3'b001;
        step(1'b1, 1'b0, acc);
        check("bp_load", acc, 0);
        pend[2] = rand_txn();
        pend_val = 3'b100;
        repeat (4) begin
            step(1'b0, 1'b0, acc);
            check("bp_rdy", X_rdy, 0);
            check("bp_seq", C_seq_num, 7);
            check("bp_rfwen", rf_wen, 0);
        end
        step(1'b1, 1'b0, acc);
        check("bp_release_rf", rf_wen, pend[0].wen && pend[0].waddr != 0);
        check("bp_release_acc", acc, 2);
        pend_val = '0;
        step(1'b1, 1'b0, acc);
        check("bp_next_seq", C_seq_num, pend[2].seq);

        // x0 destination
        pend[0] = rand_txn();
        pend[0].waddr = 5'd0;
        pend[0].wen = 1'b1;
        pend_val = 3'b001;
        step(1'b1, 1'b0, acc);
        check("x0_acc", acc, 0);
        pend_val = '0;
        step(1'b1, 1'b0, acc);
        check("x0_cval", C_val, 1);
        check("x0_cwen", C_wen, 0);
        check("x0_rfwen", rf_wen, 0);

        // Reset while an entry is held under backpressure with ptr=2
        pend[1] = rand_txn();
        pend_val = 3'b010;
        step(1'b1, 1'b0, acc);
        pend_val = '0;
        step(1'b0, 1'b0, acc);
        check("rm_held", C_val, 1);
        step(1'b0, 1'b1, acc);
        step(1'b0, 1'b0, acc);
        check("rm_cval", C_val, 0);
        check("rm_rfwen", rf_wen, 0);
        for (int i = 0; i < N; i++) pend[i] = rand_txn();
        pend_val = 3'b111;
        step(1'b1, 1'b0, acc);
        check("rm_first", acc, 0);
        pend_val = '0;
        step(1'b1, 1'b0, acc);

        // Fairness: pipe0 always valid, pipe1 joins later
        pend_val = 3'b001;
        repeat (2) begin
            step(1'b1, 1'b0, acc);
            if (acc >= 0) pend[acc] = rand_txn();
        end
        pend_val = 3'b011;
        cnt = 0;
        for (int j = 0; j < 4; j++) begin
            step(1'b1, 1'b0, acc);
            if (acc >= 0) begin
                cnt++;
                pend[acc] = rand_txn();
            end
            if (acc == 1) break;
        end
        check("fair_pipe1", (acc == 1) && (cnt <= 2), 1);

        // Random traffic
        for (int i = 0; i < N; i++) waits[i] = 0;
        pend_val = '0;
        for (int j = 0; j < 1500; j++) begin
            c_rdy = ($urandom_range(0, 9) < 7);
            r     = ($urandom_range(0, 99) == 0);
            step(c_rdy, r, acc);
            for (int i = 0; i < N; i++) begin
                if (r) begin
                    waits[i] = 0;
                end else if (acc == i) begin
                    check("starve", waits[i] <= N - 1, 1);
                    waits[i] = 0;
                end else if (pend_val[i] && acc >= 0) begin
                    waits[i]++;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (acc == i) begin
                    pend[i] = rand_txn();
                    pend_val[i] = ($urandom_range(0, 9) < 6);
                end else if (!pend_val[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = rand_txn();
                    pend_val[i] = 1'b1;
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/writeback_arb_l6.md
Name: writeback_arb_l6

Overview:
- Writeback stage sitting directly downstream of the execute units (ALU, multiplier, memory, etc.).
- Each execute unit presents a completed instruction on a val/rdy X→W channel. This block selects one per cycle with round-robin arbitration and holds it in a one-entry output register.
- Drives the physical register file write port and forwards the completion to the commit/ROB stage over a val/rdy channel.
- Sustains one completion per cycle when commit is ready.

Parameters:
- p_num_pipes, 3, number of execute-unit X→W channels (≥2).
- p_seq_num_bits, 5, sequence number width.
- p_phys_addr_bits, 6, physical register address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- X_val  in  p_num_pipes  per-pipe valid
- X_rdy  out  p_num_pipes  per-pipe ready
- X_pc  in  p_num_pipes*32  per-pipe PC (pipe i at bits [32i+31:32i]; same packing for all X_ fields)
- X_seq_num  in  p_num_pipes*p_seq_num_bits  sequence number
- X_waddr  in  p_num_pipes*5  architectural destination
- X_wdata  in  p_num_pipes*32  result
- X_wen  in  p_num_pipes  destination-write request
- X_preg  in  p_num_pipes*p_phys_addr_bits  new physical destination
- X_ppreg  in  p_num_pipes*p_phys_addr_bits  previous physical mapping
- rf_wen  out  1  physical regfile write enable
- rf_waddr  out  p_phys_addr_bits  regfile write address (=held preg)
- rf_wdata  out  32  regfile write data
- C_val  out  1  completion valid to commit
- C_rdy  in  1  commit ready
- C_pc, C_seq_num, C_waddr, C_wdata, C_wen, C_preg, C_ppreg  out  (widths as X_ per-pipe)  held completion fields

Behaviour:
- Reset: rst synchronous, active-high; clock clk.
  - Output register cleared to all-zero: C_val=0, all C_ fields 0, rf_wen=0.
  - Round-robin pointer ptr=0.
  - A held entry is dropped by reset mid-operation, even while C_rdy=0.
- Arbitration (combinational):
  - grant = first i with X_val[i]=1, scanning ptr, ptr+1, … modulo p_num_pipes.
  - grant does not depend on C_rdy or X_rdy.
- Acceptance:
  - can_accept = !C_val | C_rdy.
  - X_rdy[i] = can_accept & grant[i]. At most one X_rdy is high per cycle.
  - Zero-valid-input cycles: all X_rdy=0.
- Output register update at each posedge, in priority order:
  - If an accept occurs (X_xfer): load the granted pipe's fields with val=1. This also covers the same-cycle C transfer case (simultaneous dequeue/enqueue at full throughput).
  - Else if C_val & C_rdy: clear to 0.
  - Else: hold.
  - Held fields remain stable while C_val=1 & C_rdy=0.
- Pointer update:
  - On accept from pipe i: ptr <= (i+1) mod p_num_pipes. The last pipe wraps to 0.
  - Otherwise ptr holds.
  - A starved pipe waits at most p_num_pipes-1 accepts.
- x0 rule:
  - On load, stored C_wen = X_wen[i] & (X_waddr[i] != 0).
  - Other fields are stored unmodified.
- Register-file write:
  - rf_wen = C_val & C_rdy & C_wen. The write occurs exactly in the cycle the completion transfers to commit, never twice for one entry.
  - rf_waddr = C_preg; rf_wdata = C_wdata.
- Latency: one cycle from X transfer to C_val=1. Throughput: 1 per cycle.
- X-channel inputs are ignored when not granted. Unchosen pipes must hold their data (val/rdy contract).

Test Plan:
- Single pipe: pipe1 presents seq 3, waddr 5, wdata 0x1234, preg 9, wen=1, C_rdy=1 -> X_rdy[1]=1 that cycle. Next cycle C_val=1, C_seq_num=3, rf_wen=1, rf_waddr=9, rf_wdata=0x1234. The following cycle C_val=0.
- Contention, N=3, all three valid continuously, C_rdy=1 -> accepts in order pipe 0,1,2,0,… one per cycle, ptr wrapping 2→0, C_val continuously 1.
- Backpressure: hold C_rdy=0 for 4 cycles with pipe0 (seq 7) held and pipe2 valid -> all X_rdy=0, C_ fields stable at seq 7, rf_wen=0. On C_rdy=1: rf_wen pulses once, pipe2 is accepted the same cycle and appears next cycle.
- x0: pipe0 presents waddr 0, wen=1 -> C_wen=0 and rf_wen=0 on transfer; C_val still 1.
- Reset mid-operation: entry held with C_rdy=0, ptr=2, assert rst one cycle -> C_val=0, rf_wen=0, ptr=0. A subsequent all-valid test grants pipe 0 first.
- Fairness: pipe0 constantly valid, pipe1 valid from cycle 2 -> pipe1 accepted no later than the second accept after it rises.
